uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter `top`. It consumes the `tx` line and delivers 8N1 frames as parallel bytes. The block oversamples the line at 16x, validates the start bit, majority-votes each data bit at mid-bit, and checks the stop bit. Each received byte is reported with a one-cycle `valid` pulse, or with a `frame_err` pulse when the stop bit is bad.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_os_tick.sv | 30 +++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// oversample divisor calculation used by both the RX and TX sides.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clkfreq, input int bauds, input int os);
        return clkfreq / (bauds * os);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus parallel result bundle of the UART receiver.
// slave: the receiver itself; master: whoever drives the line and consumes bytes.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport slave (
        input  rx,
        output data_out,
        output valid,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        input  data_out,
        input  valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter that pulses
// tick on its last count. clear realigns the phase (e.g. to a start edge).
module uart_os_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Divider counter; restarts from zero on clear or after the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x (configurable) oversampling, start-bit
// validation at mid-start, 2-of-3 majority voting around each mid-bit and
// stop-bit checking. Results are reported with one-cycle valid/frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKFREQ    = 50_000_000,
    parameter int BAUDS      = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int DIV = calc_div(CLKFREQ, BAUDS, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    // Sample-counter positions: mid-start, and the two votes before the wrap.
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE - 2);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic                 rx_q_reg;
    logic                 start_edge;
    logic                 os_tick;
    logic                 vote;

    uart_rx_state_t       state_reg;
    logic [SW-1:0]        s_cnt_reg;
    logic [BW-1:0]        b_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 v0_reg;
    logic                 v1_reg;
    logic                 pending_reg;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 busy_reg;

    // Two-flop synchronizer for the asynchronous line plus one delay flop
    // for falling-edge detection; all idle high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
            rx_q_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], bus.rx};
            rx_q_reg <= sync_reg[1];
        end
    end

    assign rx_s = sync_reg[1];

    // A held-low line never produces a second edge because rx_q must be high.
    assign start_edge = (state_reg == IDLE) && rx_q_reg && !rx_s;

    // The third vote is taken live on the wrap tick, together with the two
    // stored samples from the preceding ticks.
    assign vote = (v0_reg & v1_reg) | (v0_reg & rx_s) | (v1_reg & rx_s);

    uart_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_edge),
        .tick  (os_tick)
    );

    // Receive FSM: start validation, data voting/shifting, stop check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            s_cnt_reg     <= '0;
            b_cnt_reg     <= '0;
            shift_reg     <= '0;
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            pending_reg   <= 1'b0;
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        s_cnt_reg   <= '0;
                        pending_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= START;
                    end
                end

                START: begin
                    if (os_tick) begin
                        if (s_cnt_reg == S_MID) begin
                            if (rx_s) begin
                                // Line back high by mid-start: a glitch.
                                busy_reg  <= 1'b0;
                                state_reg <= IDLE;
                            end else begin
                                // Phase is now referenced to mid-start.
                                s_cnt_reg   <= '0;
                                b_cnt_reg   <= '0;
                                pending_reg <= 1'b0;
                                state_reg   <= DATA;
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + 1'b1;
                        end
                    end
                end

                DATA, STOP: begin
                    if (os_tick) begin
                        s_cnt_reg <= (s_cnt_reg == S_LAST) ? '0 : s_cnt_reg + 1'b1;

                        if (s_cnt_reg == S_V0) begin
                            v0_reg <= rx_s;
                        end

                        if (s_cnt_reg == S_LAST) begin
                            v1_reg      <= rx_s;
                            pending_reg <= 1'b1;
                        end

                        // The zero position right after entering DATA has no
                        // stored samples yet, hence the pending qualifier.
                        if ((s_cnt_reg == '0) && pending_reg) begin
                            pending_reg <= 1'b0;
                            if (state_reg == DATA) begin
                                shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                                if (b_cnt_reg == B_LAST) begin
                                    state_reg <= STOP;
                                end else begin
                                    b_cnt_reg <= b_cnt_reg + 1'b1;
                                end
                            end else begin
                                data_out_reg  <= shift_reg;
                                valid_reg     <= vote;
                                frame_err_reg <= !vote;
                                busy_reg      <= 1'b0;
                                state_reg     <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_reg;
    assign bus.valid     = valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serial transmitter drives the line with
// configurable bit periods; every frame sent records the expected outcome
// (byte, good/bad stop) and a monitor collects the pulses actually seen.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLKFREQ  = 64_000_000;
    localparam int BAUDS    = 1_000_000;
    localparam int OS       = 16;
    localparam int DIV      = CLKFREQ / (BAUDS * OS);   // 4 clocks per tick
    localparam int BIT_CLKS = DIV * OS;                 // 64 clocks per bit
    localparam int BIT_NS   = BIT_CLKS * 10;            // 10 ns clock
    localparam int LAT_NOM  = (19 * BIT_CLKS) / 2 + 3;  // 9.5 bits + 3 clocks
    localparam int LAT_LO   = LAT_NOM - DIV;
    localparam int LAT_HI   = LAT_NOM + DIV + 2;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   both_cnt = 0;

    pulse_t got_q[$];
    pulse_t exp_q[$];

    uart_rx_if bus();

    uart_rx #(
        .CLKFREQ    (CLKFREQ),
        .BAUDS      (BAUDS),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid || bus.frame_err) begin
                pulse_t p;
                p.data = bus.data_out;
                p.err  = bus.frame_err;
                p.cyc  = cyc;
                got_q.push_back(p);
            end
            if (bus.valid && bus.frame_err) both_cnt++;
        end
    end

    initial begin
        #600us;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Serial transmitter and reference model: a frame with a good stop bit
    // yields valid+byte, a low stop bit yields frame_err+byte.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns,
                              output int start_cyc);
        pulse_t e;
        e.data = b;
        e.err  = !stop;
        e.cyc  = 0;
        exp_q.push_back(e);
        bus.rx = 1'b0;
        start_cyc = cyc;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        bus.rx = stop;
        #(bit_ns);
    endtask

    task automatic check_pulses(input string tag);
        int waited;
        int n;
        waited = 0;
        while ((got_q.size() < exp_q.size()) && (waited < 3000)) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            check({tag, "_err"}, got_q[i].err, exp_q[i].err);
        end
        $display("[TB] %s: %0d pulse(s) expected, %0d seen", tag, exp_q.size(), got_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int sc;
        int lat;
        int bn;
        int idle;
        logic [7:0] b;
        logic stop;

        bus.rx = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        #100;

        // Two ordinary frames; latency of the first one is checked.
        send_frame(8'hA5, 1'b1, BIT_NS, sc);
        lat = (got_q.size() > 0) ? (got_q[0].cyc - sc) : -1;
        n_tests++;
        assert ((lat >= LAT_LO) && (lat <= LAT_HI)) else begin
            n_fail++;
            $error("FAIL a5_latency: observed %0d clocks required %0d..%0d", lat, LAT_LO, LAT_HI);
        end
        #(3 * BIT_NS);
        send_frame(8'h3C, 1'b1, BIT_NS, sc);
        #(2 * BIT_NS);
        check_pulses("loop");

        // Short low glitch: busy rises, then drops by mid-start, no pulse.
        bus.rx = 1'b0;
        #100;
        check("glitch_busy_hi", bus.busy, 1'b1);
        #100;
        bus.rx = 1'b1;
        #300;
        check("glitch_busy_lo", bus.busy, 1'b0);
        check("glitch_data_kept", bus.data_out, 8'h3C);
        #(2 * BIT_NS);
        check_pulses("glitch");

        // Bad stop bit, then the line stays low for 10 bits: one frame_err only.
        send_frame(8'h55, 1'b0, BIT_NS, sc);
        #(10 * BIT_NS);
        check_pulses("ferr");
        check("ferr_low_busy", bus.busy, 1'b0);
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        send_frame(8'h0F, 1'b1, BIT_NS, sc);
        #(2 * BIT_NS);
        check_pulses("after_ferr");

        // Back-to-back frames with zero idle.
        send_frame(8'h00, 1'b1, BIT_NS, sc);
        send_frame(8'hFF, 1'b1, BIT_NS, sc);
        send_frame(8'h81, 1'b1, BIT_NS, sc);
        #(2 * BIT_NS);
        check_pulses("b2b");

        // Reset in the middle of bit 4.
        b = 8'h5A;
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            #(BIT_NS);
        end
        bus.rx = b[4];
        #(BIT_NS / 2);
        rst = 1'b1;
        #2;
        check("midrst_data_out", bus.data_out, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_valid", bus.valid, 1'b0);
        check("midrst_frame_err", bus.frame_err, 1'b0);
        #8;
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        rst = 1'b0;
        #(12 * BIT_NS);
        check_pulses("midrst");
        send_frame(8'hC3, 1'b1, BIT_NS, sc);
        #(2 * BIT_NS);
        check_pulses("after_rst");

        // Transmitter 2.5% slow.
        send_frame(8'hB2, 1'b1, (BIT_NS * 1025) / 1000, sc);
        #(2 * BIT_NS);
        check_pulses("slow");

        // Random bytes, random stop quality, small rate offsets, random gaps.
        for (int k = 0; k < 16; k++) begin
            b    = 8'($urandom);
            bn   = 630 + 2 * int'($urandom_range(0, 10));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, bn, sc);
            idle = int'($urandom_range(0, 2));
            if (!stop) begin
                bus.rx = 1'b1;
                if (idle == 0) idle = 1;
            end
            #(idle * bn);
        end
        bus.rx = 1'b1;
        #(2 * BIT_NS);
        check_pulses("rand");

        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
